// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and helpers for the iterative Hi/Lo multiply/divide unit.
// Op and state encodings plus the fixed request-to-Done latency.
package hilo_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int WIDTH_DEF = 32;
  localparam int LATENCY   = WIDTH_DEF + 2;

  function automatic logic is_valid_op(input logic [2:0] op);
    return op[2:1] != 2'b11;
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_divstep.sv
// One restoring-division step: trial-subtract the divisor from the already
// shifted partial remainder and keep the difference only when it is non-negative.
module hilo_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  always_comb begin
    diff    = rem_in - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Radix-2 iterative multiply/divide unit feeding the Hi/Lo registers.
// Magnitudes are iterated for WIDTH cycles, signs and accumulation applied in FIXUP.
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] HiIn,
  input  logic [WIDTH-1:0] LoIn,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_mag, b_mag, a_raw, hi_acc, lo_acc;
  logic               neg_res, neg_rem, div_zero_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem, quo;

  logic [WIDTH-1:0]          a_abs, b_abs;
  logic [WIDTH:0]            mul_sum;
  logic [WIDTH:0]            rem_shift;
  logic [WIDTH-1:0]          rem_next;
  logic                      q_next;
  logic signed [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]          quo_s, rem_s;
  logic [2*WIDTH-1:0]        fix_res;

  hilo_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in  (rem_shift),
    .divisor (b_mag),
    .rem_out (rem_next),
    .q_bit   (q_next)
  );

  always_comb begin
    a_abs     = (is_signed_op(Op) && A[WIDTH-1]) ? -A : A;
    b_abs     = (is_signed_op(Op) && B[WIDTH-1]) ? -B : B;
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_mag} : '0);
    rem_shift = {rem, quo[WIDTH-1]};
    prod_s    = neg_res ? -prod : prod;
    quo_s     = neg_res ? -quo : quo;
    rem_s     = neg_rem ? -rem : rem;
    fix_res   = prod_s;
    if (is_div_op(op_q)) begin
      fix_res = div_zero_q ? {a_raw, {WIDTH{1'b1}}} : {rem_s, quo_s};
    end else if (op_q == OP_MADD) begin
      fix_res = {hi_acc, lo_acc} + prod_s;
    end else if (op_q == OP_MSUB) begin
      fix_res = {hi_acc, lo_acc} - prod_s;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      a_mag      <= '0;
      b_mag      <= '0;
      a_raw      <= '0;
      hi_acc     <= '0;
      lo_acc     <= '0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero_q <= 1'b0;
      prod       <= '0;
      rem        <= '0;
      quo        <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      DivZero    <= 1'b0;
      HiOut      <= '0;
      LoOut      <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start && !Flush && is_valid_op(Op)) begin
            op_q       <= Op;
            a_mag      <= a_abs;
            b_mag      <= b_abs;
            a_raw      <= A;
            hi_acc     <= HiIn;
            lo_acc     <= LoIn;
            neg_res    <= is_signed_op(Op) && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_rem    <= is_signed_op(Op) && A[WIDTH-1];
            div_zero_q <= (B == '0);
            prod       <= {{WIDTH{1'b0}}, b_abs};
            rem        <= '0;
            quo        <= a_abs;
            cnt        <= '0;
            Busy       <= 1'b1;
            state      <= S_CALC;
          end
        end
        S_CALC: begin
          if (Flush) begin
            Busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (is_div_op(op_q)) begin
              rem <= rem_next;
              quo <= {quo[WIDTH-2:0], q_next};
            end else begin
              prod <= {mul_sum, prod[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          Busy <= 1'b0;
          if (Flush) begin
            state <= S_IDLE;
          end else begin
            {HiOut, LoOut} <= fix_res;
            Done           <= 1'b1;
            DivZero        <= is_div_op(op_q) && div_zero_q;
            state          <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases plus random ops checked against
// a plain-arithmetic model of the Hi/Lo results.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = LATENCY;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1, Start = 1'b0, Flush = 1'b0;
  logic [2:0]   Op = '0;
  logic [W-1:0] A = '0, B = '0, HiIn = '0, LoIn = '0;
  logic         Busy, Done, DivZero;
  logic [W-1:0] HiOut, LoOut;

  logic [W:0]   ds_rem;
  logic [W-1:0] ds_div, ds_rem_out;
  logic         ds_q;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] last_hi = '0, last_lo = '0;

  always #5 Clk = ~Clk;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiIn(HiIn), .LoIn(LoIn), .Flush(Flush), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .HiOut(HiOut), .LoOut(LoOut)
  );

  hilo_divstep #(.WIDTH(W)) u_ds (
    .rem_in(ds_rem), .divisor(ds_div), .rem_out(ds_rem_out), .q_bit(ds_q)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {divzero, hi, lo} straight from the arithmetic meaning of each op
  function automatic logic [64:0] model(input logic [2:0] op, input logic [W-1:0] a, b, hi, lo);
    longint sa, sb;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {hi, lo};
    case (op)
      OP_MULT:  return {1'b0, 64'(sa * sb)};
      OP_MULTU: return {1'b0, {32'b0, a} * {32'b0, b}};
      OP_MADD:  return {1'b0, acc + 64'(sa * sb)};
      OP_MSUB:  return {1'b0, acc - 64'(sa * sb)};
      OP_DIV:   if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                else        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                else        return {1'b0, a % b, a / b};
      default:  return {1'b0, hi, lo};
    endcase
  endfunction

  // flush_at==0 asserts Flush together with Start; negative means never
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, hi_in, lo_in,
                        input int restart_at, flush_at, rst_at,
                        output int done_cnt, done_cyc, busy_bad, dz_stray,
                        output logic [W-1:0] r_hi, r_lo, output logic r_dz,
                        output logic ab_busy, output logic [W-1:0] ab_hi, ab_lo);
    int   abort;
    logic accepted, exp_busy;
    abort    = (flush_at > 0) ? flush_at : ((rst_at > 0) ? rst_at : -1);
    accepted = (op[2:1] != 2'b11) && (flush_at != 0);
    done_cnt = 0; done_cyc = 0; busy_bad = 0; dz_stray = 0;
    r_hi = '0; r_lo = '0; r_dz = 1'b0; ab_busy = 1'b0; ab_hi = '0; ab_lo = '0;
    @(negedge Clk);
    Op = op; A = a; B = b; HiIn = hi_in; LoIn = lo_in;
    Start = 1'b1; Flush = (flush_at == 0); Rst = 1'b0;
    for (int n = 1; n <= LAT + 3; n++) begin
      @(negedge Clk);
      Start = (n == restart_at);
      if (n == restart_at) begin
        A = $urandom; B = $urandom; HiIn = $urandom; LoIn = $urandom;
      end
      Flush = (n == flush_at);
      Rst   = (n == rst_at);
      exp_busy = accepted && (n <= LAT - 1) && (abort < 0 || n <= abort);
      if (Busy !== exp_busy) busy_bad++;
      if (Done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = n; r_hi = HiOut; r_lo = LoOut; r_dz = DivZero;
        end
      end else if (DivZero !== 1'b0) begin
        dz_stray++;
      end
      if (abort >= 0 && n == abort + 1) begin
        ab_busy = Busy; ab_hi = HiOut; ab_lo = LoOut;
      end
    end
    Start = 1'b0; Flush = 1'b0; Rst = 1'b0;
  endtask

  task automatic do_full(input string tag, input logic [2:0] op, input logic [W-1:0] a, b, hi_in, lo_in,
                         input int flush_at, output logic [W-1:0] o_hi, o_lo, output logic o_dz);
    int dc, dcy, bb, ds;
    logic ab; logic [W-1:0] ah, al;
    logic [64:0] exp;
    exp = model(op, a, b, hi_in, lo_in);
    run_op(op, a, b, hi_in, lo_in, -1, flush_at, -1, dc, dcy, bb, ds, o_hi, o_lo, o_dz, ab, ah, al);
    chk({tag, " done_count"}, 64'(dc), 64'd1);
    chk({tag, " done_cycle"}, 64'(dcy), 64'(LAT));
    chk({tag, " busy_window_errors"}, 64'(bb), 64'd0);
    chk({tag, " divzero_outside_done"}, 64'(ds), 64'd0);
    chk({tag, " hi"}, 64'(o_hi), 64'(exp[63:32]));
    chk({tag, " lo"}, 64'(o_lo), 64'(exp[31:0]));
    chk({tag, " divzero"}, 64'(o_dz), 64'(exp[64]));
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  initial begin
    logic [W-1:0] h, l;
    logic         dz, ab;
    logic [W-1:0] ah, al;
    logic [63:0]  r64, lim;
    logic [2:0]   rop;
    int dc, dcy, bb, ds;

    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    chk("reset busy", 64'(Busy), 64'd0);
    chk("reset done", 64'(Done), 64'd0);
    chk("reset divzero", 64'(DivZero), 64'd0);
    chk("reset hi", 64'(HiOut), 64'd0);
    chk("reset lo", 64'(LoOut), 64'd0);

    for (int i = 0; i < 6; i++) begin
      ds_div = $urandom | 32'h1;
      lim    = 64'(ds_div) * 2;
      r64    = {$urandom, $urandom} % lim;
      if (i == 0) r64 = 64'(ds_div);
      if (i == 1) r64 = 64'(ds_div) - 1;
      ds_rem = r64[W:0];
      #1;
      chk("divstep qbit", 64'(ds_q), (r64 >= 64'(ds_div)) ? 64'd1 : 64'd0);
      chk("divstep rem", 64'(ds_rem_out), (r64 >= 64'(ds_div)) ? r64 - 64'(ds_div) : r64);
    end

    do_full("t1_mult", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'h0, -1, h, l, dz);
    chk("t1 hi const", 64'(h), 64'hFFFF_FFFF);
    chk("t1 lo const", 64'(l), 64'hFFFF_FFEB);
    do_full("t2_multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, -1, h, l, dz);
    chk("t2 multu const", {32'(h), 32'(l)}, 64'hFFFF_FFFE_0000_0001);
    do_full("t2_madd", OP_MADD, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, -1, h, l, dz);
    chk("t2 madd const", {32'(h), 32'(l)}, 64'h0000_0001_0000_0000);
    do_full("t3_div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, -1, h, l, dz);
    chk("t3 div const", {32'(h), 32'(l)}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_full("t3_div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, -1, h, l, dz);
    chk("t3 div_ovf const", {32'(h), 32'(l)}, 64'h0000_0000_8000_0000);
    do_full("t4_divu0", OP_DIVU, 32'h1234, 32'h0, 32'h0, 32'h0, -1, h, l, dz);
    chk("t4 divzero const", {31'b0, dz, 32'(h)}, 64'h1_0000_1234);

    // second Start mid-operation is ignored
    run_op(OP_MULT, 32'd123, 32'hFFFF_FE38, 32'h0, 32'h0, 5, -1, -1, dc, dcy, bb, ds, h, l, dz, ab, ah, al);
    chk("t5 restart done_count", 64'(dc), 64'd1);
    chk("t5 restart done_cycle", 64'(dcy), 64'(LAT));
    chk("t5 restart result", {32'(h), 32'(l)}, 64'(model(OP_MULT, 32'd123, 32'hFFFF_FE38, 0, 0)));
    last_hi = h; last_lo = l;

    run_op(OP_DIVU, $urandom, $urandom | 1, 32'h0, 32'h0, -1, 10, -1, dc, dcy, bb, ds, h, l, dz, ab, ah, al);
    chk("t5 flush done_count", 64'(dc), 64'd0);
    chk("t5 flush busy_window_errors", 64'(bb), 64'd0);
    chk("t5 flush outputs held", {32'(HiOut), 32'(LoOut)}, {32'(last_hi), 32'(last_lo)});

    run_op(OP_MULTU, 32'd9, 32'd9, 32'h0, 32'h0, -1, LAT - 1, -1, dc, dcy, bb, ds, h, l, dz, ab, ah, al);
    chk("flush_in_fixup done_count", 64'(dc), 64'd0);
    chk("flush_in_fixup outputs held", {32'(HiOut), 32'(LoOut)}, {32'(last_hi), 32'(last_lo)});

    run_op(OP_MULTU, 32'd9, 32'd9, 32'h0, 32'h0, -1, 0, -1, dc, dcy, bb, ds, h, l, dz, ab, ah, al);
    chk("flush_with_start done_count", 64'(dc), 64'd0);
    chk("flush_with_start busy_window_errors", 64'(bb), 64'd0);

    rop = 3'b110;
    run_op(rop, 32'd5, 32'd6, 32'h0, 32'h0, -1, -1, -1, dc, dcy, bb, ds, h, l, dz, ab, ah, al);
    chk("reserved_op done_count", 64'(dc), 64'd0);
    chk("reserved_op busy_window_errors", 64'(bb), 64'd0);
    chk("reserved_op outputs held", {32'(HiOut), 32'(LoOut)}, {32'(last_hi), 32'(last_lo)});

    // Flush arriving in the DONE cycle must not cancel the pulse
    do_full("flush_in_done_msub", OP_MSUB, $urandom, $urandom, $urandom, $urandom, LAT, h, l, dz);

    run_op(OP_DIV, $urandom, $urandom | 1, 32'h0, 32'h0, -1, -1, 20, dc, dcy, bb, ds, h, l, dz, ab, ah, al);
    chk("t6 reset done_count", 64'(dc), 64'd0);
    chk("t6 reset busy_window_errors", 64'(bb), 64'd0);
    chk("t6 reset busy after", 64'(ab), 64'd0);
    chk("t6 reset outputs cleared", {32'(ah), 32'(al)}, 64'd0);
    last_hi = '0; last_lo = '0;
    do_full("t6_multu", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'h0, -1, h, l, dz);
    chk("t6 multu const", {32'(h), 32'(l)}, 64'd15);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 3 == 0) ra = ra >> $urandom_range(0, 31);
      if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
      if (i % 7 == 2) rb = '0;
      do_full("random", rop, ra, rb, $urandom, $urandom, -1, h, l, dz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Iterative multiply/divide unit that produces the Hi/Lo register pair for the Datapath. It sits in the execute stage, directly upstream of the Hi/Lo registers. It accepts MULT/MULTU/DIV/DIVU/MADD/MSUB requests with a start/busy/done handshake and computes radix-2, one bit per cycle. On completion it presents a 64-bit result that the Datapath writes into Hireg/Loreg.

Parameters:
WIDTH, 32, operand width; the Hi and Lo results are WIDTH bits each.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  synchronous, active-high reset.
Start  in  1  request strobe; accepted only in IDLE.
Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 11x reserved.
A  in  WIDTH  rs operand; multiplicand or dividend.
B  in  WIDTH  rt operand; multiplier or divisor.
HiIn  in  WIDTH  current Hireg; accumulator for MADD/MSUB.
LoIn  in  WIDTH  current Loreg; accumulator for MADD/MSUB.
Flush  in  1  synchronous abort of the operation in flight.
Busy  out  1  operation in progress (CALC or FIXUP).
Done  out  1  one-cycle pulse; HiOut/LoOut valid and updated.
DivZero  out  1  pulses with Done when a DIV/DIVU has B==0.
HiOut  out  WIDTH  product high word, or remainder.
LoOut  out  WIDTH  product low word, or quotient.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; Busy=0, Done=0, DivZero=0, HiOut=0, LoOut=0; all internal registers cleared.
- Reset has priority over every other input, including mid-operation. A reset mid-operation produces no Done.
- States:
  - IDLE: waits for Start.
  - CALC: WIDTH iterations.
  - FIXUP: sign correction and accumulate.
  - DONE: Done=1 for one cycle, then return to IDLE.
- Accept (cycle 0): Start=1 in IDLE with a valid Op.
  - A, B, Op, HiIn and LoIn are sampled.
  - Signed ops store |A| and |B| and record the result and remainder signs.
  - Next state is CALC.
- Reserved Op: Start is ignored; the unit stays in IDLE and produces no Done.
- Start while not in IDLE is ignored (not queued). The Datapath must stall on Busy.
- Latency: CALC runs cycles 1..WIDTH, FIXUP is cycle WIDTH+1, Done is high in cycle WIDTH+2 (34 for WIDTH=32).
- Busy=1 from cycle 1 through WIDTH+1. Busy=0 in the DONE cycle.
- HiOut/LoOut update on the edge entering DONE. They hold their value until the next completion; Flush and rejected Starts do not change them.
- Multiply: shift-add on an unsigned 2*WIDTH product. MULT/MADD/MSUB treat operands as signed; MULTU as unsigned.
- FIXUP for multiply:
  - Negate the product if the operand signs differ (signed ops only).
  - MADD: {Hi,Lo} = {HiIn,LoIn} + product.
  - MSUB: {Hi,Lo} = {HiIn,LoIn} - product.
  - Arithmetic is modulo 2^(2*WIDTH); no overflow flag.
- Divide: restoring division of |A| by |B| with a (WIDTH+1)-bit partial remainder.
- FIXUP for divide:
  - Quotient is negated if the signs differ; remainder takes the dividend's sign (truncating division).
  - 0x80000000 / -1 gives Lo=0x80000000, Hi=0 with no trap.
- Divide by zero: still takes the full latency. Result is Hi=A (raw), Lo=all ones, DivZero=1 in the DONE cycle.
- Flush: in CALC or FIXUP, returns to IDLE next edge with no Done and outputs unchanged.
  - Flush in IDLE or DONE has no effect; an in-progress Done pulse still completes.
  - Flush and Start in the same IDLE cycle: Flush wins and Start is dropped.
- Iteration counter: clog2(WIDTH)+1 bits; it must not wrap before the WIDTH-th iteration.

Decomposition:
- Shared package holds:
  - Op encodings (OP_MULT..OP_MSUB).
  - State encodings (S_IDLE, S_CALC, S_FIXUP, S_DONE).
  - The LATENCY = WIDTH+2 constant.
- One natural sub-module, hilo_divstep: the combinational restoring-division step (partial remainder and divisor in; next remainder and quotient bit out). It is reused by the bench model.
- The multiply step stays inline.

Test Plan:
1. MULT A=7, B=0xFFFFFFFD -> Done exactly 34 cycles after Start; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for cycles 1..33.
2. MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. MADD with HiIn=0, LoIn=0xFFFFFFFF, A=1, B=1 -> Hi=1, Lo=0.
3. DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
4. DIVU A=0x1234, B=0 -> Hi=0x1234, Lo=0xFFFFFFFF, DivZero=1 in the Done cycle only.
5. Start MULT, pulse Start again at cycle 5 with new operands -> a single Done at cycle 34 with the first result. Flush at cycle 10 of a second op -> no Done; HiOut/LoOut keep the first result.
6. Assert Rst at cycle 20 of a DIV -> no Done; next cycle Busy=0, HiOut=0, LoOut=0. A fresh MULTU 3*5 then gives Lo=15, Hi=0 at cycle 34.
